// File: rtl/hazard_ctrl_if.sv
// Control/status bundle between the decode-side hazard scheduler and the pipeline.
// The slave side is the scheduler; the master side is the pipeline (or a bench).
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_rsUsed;
  logic             id_rtUsed;
  logic             id_halt;
  logic             ex_memRead;
  logic             ex_regWrite;
  logic [2:0]       ex_writeReg;
  logic             ex_taken;
  logic             imem_stall;
  logic             dmem_stall;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             validIns;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_rsUsed, id_rtUsed, id_halt,
           ex_memRead, ex_regWrite, ex_writeReg, ex_taken,
           imem_stall, dmem_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, validIns, halted, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rsUsed, id_rtUsed, id_halt,
           ex_memRead, ex_regWrite, ex_writeReg, ex_taken,
           imem_stall, dmem_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_bubble, validIns, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall scheduler: prioritised stall and flush decisions in RUN,
// then a fixed-length drain after a halt until the core is quiesced.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             halted_q;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_bubble, valid_ins;
  logic load_use;

  assign load_use = bus.ex_memRead & bus.ex_regWrite &
                    ((bus.id_rsUsed & (bus.id_rs == bus.ex_writeReg)) |
                     (bus.id_rtUsed & (bus.id_rt == bus.ex_writeReg)));

  always_comb begin
    // NOTE: every output gets a value before any branch so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    valid_ins   = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;

    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.dmem_stall) begin
            // Whole pipe frozen; an ex_taken stays latched in EX until this clears.
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            valid_ins   = 1'b1;
          end else if (bus.ex_taken) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          end else if (load_use) begin
            {idex_en, exmem_en, memwb_en} = '1;
            ifid_flush = 1'b0;
            valid_ins  = 1'b1;
          end else if (bus.imem_stall) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = '1;
            idex_bubble = 1'b0;
            valid_ins   = 1'b1;
          end else if (bus.id_halt) begin
            // Halt moves on into EX; nothing behind it is fetched.
            {ifid_en, idex_en, exmem_en, memwb_en} = '1;
            idex_bubble = 1'b0;
            valid_ins   = 1'b1;
            state_d     = ST_DRAIN;
            drain_cnt_d = DW'(DRAIN_CYCLES - 1);
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            valid_ins   = 1'b1;
          end
        end

        ST_DRAIN: begin
          if (!bus.dmem_stall) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = '1;
            if (drain_cnt_q == '0) state_d = ST_HALTED;
            else                   drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end

        ST_HALTED: ;

        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= (state_d == ST_HALTED);
      if ((state_q == ST_RUN) && !pc_en && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.validIns    = valid_ins;
  assign bus.halted      = halted_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge and all
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_hazard_ctrl;
  localparam int CNT_W = 16;

  // Control vector layout: {pc, ifid, idex, exmem, memwb, flush, bubble, valid}
  localparam logic [7:0] V_RESET  = 8'b00000_110;
  localparam logic [7:0] V_NORM   = 8'b11111_001;
  localparam logic [7:0] V_TAKEN  = 8'b11111_110;
  localparam logic [7:0] M_NOVAL  = 8'b11111_110;  // validIns left free
  localparam logic [7:0] V_LU     = 8'b00111_010;
  localparam logic [7:0] V_DSTALL = 8'b00000_000;
  localparam logic [7:0] V_IMEM   = 8'b01111_100;
  localparam logic [7:0] M_HALT   = 8'b10111_100;
  localparam logic [7:0] V_HALT   = 8'b00111_100;
  localparam logic [7:0] M_DRAIN  = 8'b10111_111;  // ifid_en left free
  localparam logic [7:0] V_DRAIN  = 8'b00111_110;
  localparam logic [7:0] M_ENVAL  = 8'b11111_001;
  localparam logic [7:0] V_QUIET  = 8'b00000_000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] ctl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_bubble, bus.validIns};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_rs       = 3'd0;
    bus.id_rt       = 3'd0;
    bus.id_rsUsed   = 1'b0;
    bus.id_rtUsed   = 1'b0;
    bus.id_halt     = 1'b0;
    bus.ex_memRead  = 1'b0;
    bus.ex_regWrite = 1'b0;
    bus.ex_writeReg = 3'd0;
    bus.ex_taken    = 1'b0;
    bus.imem_stall  = 1'b0;
    bus.dmem_stall  = 1'b0;
  endtask

  // Advance one rising edge, land on the next falling edge.
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next();
    #1;
    check("reset_ctl",     32'(ctl()),         32'(V_RESET));
    check("reset_halted",  32'(bus.halted),    32'd0);
    check("reset_cnt",     32'(bus.stall_cnt), 32'd0);

    next(); rst = 1'b0; #1;
    check("idle_ctl", 32'(ctl()), 32'(V_NORM));

    // Load-use on rs: one stall cycle, counter 0 -> 1
    next();
    bus.ex_memRead = 1'b1; bus.ex_regWrite = 1'b1; bus.ex_writeReg = 3'd3;
    bus.id_rs = 3'd3; bus.id_rsUsed = 1'b1;
    #1;
    check("lu_ctl",     32'(ctl() & M_NOVAL), 32'(V_LU));
    check("lu_cnt_pre", 32'(bus.stall_cnt),  32'd0);
    next();
    bus.ex_memRead = 1'b0; bus.ex_regWrite = 1'b1; bus.ex_writeReg = 3'd5;
    #1;
    check("lu_after_ctl", 32'(ctl()),         32'(V_NORM));
    check("lu_cnt_post",  32'(bus.stall_cnt), 32'd1);

    // rt matches the load but is not read: no hazard
    next();
    clear_inputs();
    bus.ex_memRead = 1'b1; bus.ex_regWrite = 1'b1; bus.ex_writeReg = 3'd6;
    bus.id_rt = 3'd6; bus.id_rtUsed = 1'b0; bus.id_rs = 3'd2; bus.id_rsUsed = 1'b1;
    #1;
    check("lu_unused_rt", 32'(ctl()), 32'(V_NORM));

    // Taken branch squashes a halt sitting in ID
    next();
    clear_inputs();
    bus.ex_taken = 1'b1; bus.id_halt = 1'b1;
    #1;
    check("taken_halt_ctl", 32'(ctl()), 32'(V_TAKEN));
    next();
    clear_inputs();
    #1;
    check("taken_stays_run", 32'(ctl()),         32'(V_NORM));
    check("taken_no_halt",   32'(bus.halted),    32'd0);
    check("taken_cnt",       32'(bus.stall_cnt), 32'd1);

    // dmem_stall beats ex_taken; flush follows once the stall clears
    next();
    bus.dmem_stall = 1'b1; bus.ex_taken = 1'b1;
    #1;
    check("dmem_vs_taken", 32'(ctl() & M_NOVAL), 32'(V_DSTALL));
    next();
    bus.dmem_stall = 1'b0;
    #1;
    check("taken_after_dmem", 32'(ctl()),         32'(V_TAKEN));
    check("dmem_cnt",         32'(bus.stall_cnt), 32'd2);

    // Instruction-memory stall
    next();
    clear_inputs();
    bus.imem_stall = 1'b1;
    #1;
    check("imem_ctl", 32'(ctl() & M_NOVAL), 32'(V_IMEM));

    // Halt drain, no stalls: accept at N, DRAIN N+1..N+3, halted from the N+3 closing edge
    next();
    clear_inputs();
    bus.id_halt = 1'b1;
    #1;
    check("halt_accept_ctl", 32'(ctl() & M_HALT), 32'(V_HALT));
    check("halt_cnt_pre",    32'(bus.stall_cnt),  32'd3);
    for (int i = 1; i <= 3; i++) begin
      next();
      clear_inputs();
      // Events that must all be ignored while draining
      bus.imem_stall = 1'b1; bus.ex_taken = 1'b1;
      bus.ex_memRead = 1'b1; bus.ex_regWrite = 1'b1; bus.ex_writeReg = 3'd1;
      bus.id_rs = 3'd1; bus.id_rsUsed = 1'b1;
      #1;
      check($sformatf("drain%0d_ctl", i),    32'(ctl() & M_DRAIN), 32'(V_DRAIN));
      check($sformatf("drain%0d_halted", i), 32'(bus.halted),      32'd0);
    end
    next();
    clear_inputs();
    #1;
    check("halted_set",  32'(bus.halted),        32'd1);
    check("halted_ctl",  32'(ctl() & M_ENVAL),   32'(V_QUIET));
    check("halted_cnt",  32'(bus.stall_cnt),     32'd4);
    next();
    #1;
    check("halted_holds", 32'(bus.halted), 32'd1);

    // Reset out of HALTED
    next();
    rst = 1'b1;
    #1;
    check("rst_halted_ctl", 32'(ctl()), 32'(V_RESET));
    next();
    rst = 1'b0;
    #1;
    check("post_rst_halted", 32'(bus.halted),    32'd0);
    check("post_rst_cnt",    32'(bus.stall_cnt), 32'd0);
    check("post_rst_ctl",    32'(ctl()),         32'(V_NORM));

    // Drain with a two-cycle dmem_stall: halted lands two cycles later
    next();
    bus.id_halt = 1'b1;
    #1;
    check("halt2_accept", 32'(ctl() & M_HALT), 32'(V_HALT));
    next(); clear_inputs(); #1;
    check("halt2_drain_a", 32'(ctl() & M_DRAIN), 32'(V_DRAIN));
    for (int i = 0; i < 2; i++) begin
      next(); bus.dmem_stall = 1'b1; #1;
      check($sformatf("halt2_dstall%0d", i), 32'(ctl() & M_ENVAL), 32'(V_QUIET));
    end
    next(); bus.dmem_stall = 1'b0; #1;
    check("halt2_drain_b", 32'(ctl() & M_DRAIN), 32'(V_DRAIN));
    next(); #1;
    check("halt2_drain_c",   32'(ctl() & M_DRAIN), 32'(V_DRAIN));
    check("halt2_not_yet",   32'(bus.halted),      32'd0);
    next(); #1;
    check("halt2_halted",    32'(bus.halted),      32'd1);
    check("halt2_cnt",       32'(bus.stall_cnt),   32'd1);

    // Reset in the middle of a drain returns to RUN
    next(); rst = 1'b1; next(); rst = 1'b0;
    bus.id_halt = 1'b1;
    next(); bus.id_halt = 1'b0; #1;
    check("mid_drain_state", 32'(ctl() & M_DRAIN), 32'(V_DRAIN));
    next(); rst = 1'b1; #1;
    check("mid_drain_rst_ctl", 32'(ctl()), 32'(V_RESET));
    next(); rst = 1'b0; #1;
    check("mid_drain_back_run", 32'(ctl()),      32'(V_NORM));
    check("mid_drain_halted",   32'(bus.halted), 32'd0);

    // Saturation of the stall counter under a long imem_stall
    next(); rst = 1'b1; next(); rst = 1'b0;
    bus.imem_stall = 1'b1;
    for (int i = 0; i < 65534; i++) next();
    #1;
    check("sat_ffff_minus1", 32'(bus.stall_cnt), 32'h0000_FFFE);
    next(); #1;
    check("sat_ffff", 32'(bus.stall_cnt), 32'h0000_FFFF);
    for (int i = 0; i < 6; i++) next();
    #1;
    check("sat_no_wrap", 32'(bus.stall_cnt), 32'h0000_FFFF);
    check("sat_ctl",     32'(ctl() & M_NOVAL), 32'(V_IMEM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall scheduler for the 5-stage processor. Sits beside the decode stage and drives the per-stage register enables, bubble/flush controls and the `validIns` qualifier consumed by the instruction decoder (low forces a nop decode, opcode 5'b0_0001). Resolves, in fixed priority, data-memory stalls, taken-branch/jump flushes, load-use hazards and instruction-memory stalls, and sequences the halt drain until the processor is quiesced.

## Interface
- `DRAIN_CYCLES`, 3, cycles after halt leaves ID before `halted` asserts (EX, MEM, WB).
- `CNT_W`, 16, width of the saturating stall-cycle counter.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs`, `id_rt`  in  3 each  source registers of the instruction in ID.
- `id_rsUsed`, `id_rtUsed`  in  1 each  source actually read by the ID instruction.
- `id_halt`  in  1  decoder `halt` output for the ID instruction.
- `ex_memRead`, `ex_regWrite`  in  1 each  control bits of the EX instruction.
- `ex_writeReg`  in  3  destination register of the EX instruction.
- `ex_taken`  in  1  branch taken or jump resolved in EX this cycle.
- `imem_stall`, `dmem_stall`  in  1 each  memory not ready this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  stage register write enables.
- `ifid_flush`  out  1  IF/ID loads a nop.
- `idex_bubble`  out  1  ID/EX loads a nop.
- `validIns`  out  1  qualifier to the decoder; 0 forces nop decode.
- `halted`  out  1  processor quiesced; stays high until reset.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_en`=0 in RUN.

## Operation
- FSM states: RUN, DRAIN, HALTED. Down-counter `drain_cnt` (2 bits for default).
- Decision priority in RUN, evaluated each cycle:
  1. `dmem_stall`: all five enables 0, no bubble/flush; state and counters held (except `stall_cnt`).
  2. `ex_taken`: all enables 1, `ifid_flush`=1, `idex_bubble`=1, `validIns`=0. Halt in ID is ignored (squashed).
  3. Load-use: `ex_memRead & ex_regWrite & ((id_rsUsed & id_rs==ex_writeReg) | (id_rtUsed & id_rt==ex_writeReg))`: `pc_en`=0, `ifid_en`=0, `idex_bubble`=1, others 1. Halt in ID not accepted this cycle.
  4. `imem_stall`: `pc_en`=0, `ifid_en`=1, `ifid_flush`=1, others 1.
  5. `id_halt`: `pc_en`=0, `ifid_flush`=1, `idex_en`=1; next state DRAIN, `drain_cnt`<=DRAIN_CYCLES-1.
  6. Otherwise all enables 1, bubbles/flush 0, `validIns`=1.
- DRAIN: `pc_en`=0, `ifid_flush`=1, `idex_bubble`=1, `validIns`=0; EX/MEM/WB enables 1 unless `dmem_stall` (then 0, counter holds). `imem_stall`, `ex_taken`, load-use ignored. Count 0 on a non-stalled cycle -> HALTED.
- HALTED: all enables 0, `validIns`=0, `halted`=1; only `rst` exits.
- `stall_cnt` increments when state=RUN and `pc_en`=0; saturates at all-ones, no wrap.

## Timing
- All outputs except `halted` and `stall_cnt` are combinational from inputs and state; state, `drain_cnt`, `stall_cnt`, `halted` update on `clk` rising edge.
- Reset (cycle `rst`=1 and after): state RUN, `drain_cnt`=0, `stall_cnt`=0, `halted`=0. While `rst`=1: all enables 0, `ifid_flush`=1, `idex_bubble`=1, `validIns`=0. Reset mid-DRAIN or in HALTED returns to RUN next cycle.
- Load-use stall lasts exactly 1 cycle absent other events (load advances to MEM).
- `halted` rises DRAIN_CYCLES non-dmem-stalled cycles after the cycle halt was accepted in ID.
- Simultaneous `dmem_stall` and `ex_taken`: stall wins; flush is applied on the first non-stalled cycle (`ex_taken` held by the frozen EX stage).

## Test plan
- Load-use: EX `ld r3` (`ex_memRead`=1, `ex_writeReg`=3), ID `add` with `id_rs`=3 -> one cycle `pc_en`=0, `ifid_en`=0, `idex_bubble`=1; `stall_cnt` 0->1; next cycle all enables 1.
- Branch flush with halt in ID: `ex_taken`=1, `id_halt`=1 -> `ifid_flush`=1, `idex_bubble`=1, `validIns`=0, state stays RUN, `halted` never asserts.
- Halt drain: `id_halt`=1 at cycle N, no stalls -> DRAIN at N+1, `halted`=1 at N+3 (register visible from N+3 edge), all enables 0 thereafter.
- Drain with `dmem_stall` held 2 cycles mid-drain -> `halted` delayed exactly 2 cycles; all enables 0 during the stall.
- Saturation: force `imem_stall`=1 for 2^16+5 cycles -> `stall_cnt`=16'hFFFF, no wrap.
- Reset in HALTED -> during `rst` enables 0, `validIns`=0; after release state RUN, `halted`=0, `stall_cnt`=0, all enables 1.
